// File: rtl/hdmi_tx_formatter_if.sv
// Video bus from the colour converter into the formatter, and the pin-side bus
// from the formatter to the ADV7511.
interface hdmi_tx_formatter_if #(
    parameter int unsigned DATA_W = 16
);
    logic [DATA_W-1:0] vid_data;
    logic              vid_de;
    logic              vid_hsync;
    logic              vid_vsync;

    logic              hdmi_clk;
    logic [DATA_W-1:0] hdmi_data;
    logic              hdmi_de;
    logic              hdmi_hsync;
    logic              hdmi_vsync;

    modport master (
        output vid_data, vid_de, vid_hsync, vid_vsync,
        input  hdmi_clk, hdmi_data, hdmi_de, hdmi_hsync, hdmi_vsync
    );

    modport slave (
        input  vid_data, vid_de, vid_hsync, vid_vsync,
        output hdmi_clk, hdmi_data, hdmi_de, hdmi_hsync, hdmi_vsync
    );
endinterface

// File: rtl/hdmi_tx_formatter.sv
// HDMI transmitter output stage: frame-aligned enable/disable gating, colour mute,
// sync polarity, output pipeline and active-line length checking.
module hdmi_tx_formatter #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned PIPE_STAGES = 1,
    parameter int unsigned ACTIVE_W    = 1920,
    parameter bit          HSYNC_POL   = 1'b1,
    parameter bit          VSYNC_POL   = 1'b1,
    parameter bit          CLK_INVERT  = 1'b0
) (
    input  logic                  clk_pixel,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  force_mute,
    input  logic [DATA_W-1:0]     mute_color,
    input  logic                  line_err_clr,
    hdmi_tx_formatter_if.slave    bus,
    output logic                  active,
    output logic                  line_err,
    output logic [7:0]            err_count
);
    localparam int unsigned CW = $clog2(ACTIVE_W + 2);
    localparam int unsigned SW = DATA_W + 3;
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] CNT_EXP = CW'(ACTIVE_W);
    localparam logic [SW-1:0] STAGE_RST = {1'b0, ~HSYNC_POL, ~VSYNC_POL, DATA_W'(0)};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_FRAME,
        ST_ACTIVE,
        ST_STOPPING
    } state_t;

    state_t                        state;
    state_t                        state_nxt;
    logic                          vsync_d;
    logic                          de_d;
    logic                          vs_rise;
    logic                          de_rise;
    logic                          de_fall;
    logic                          running;
    logic                          line_ok;
    logic                          line_bad;
    logic [CW-1:0]                 line_cnt;
    logic                          mux_de;
    logic                          mux_hs;
    logic                          mux_vs;
    logic [DATA_W-1:0]             mux_data;
    logic [DATA_W-1:0]             pass_data;
    logic [SW-1:0]                 stage_in;
    logic [PIPE_STAGES-1:0][SW-1:0] pipe_q;
    logic [PIPE_STAGES:0][SW-1:0]   chain;

    assign vs_rise   = bus.vid_vsync & ~vsync_d;
    assign de_rise   = bus.vid_de & ~de_d;
    assign de_fall   = ~bus.vid_de & de_d;
    assign running   = (state == ST_ACTIVE) || (state == ST_STOPPING);
    assign pass_data = (force_mute && bus.vid_de) ? mute_color : bus.vid_data;

    // Next state and gating mux; syncs are handled active-high here and polarised below.
    always_comb begin
        state_nxt = state;
        mux_de    = 1'b0;
        mux_hs    = 1'b0;
        mux_vs    = 1'b0;
        mux_data  = '0;
        case (state)
            ST_IDLE: begin
                if (enable) state_nxt = ST_WAIT_FRAME;
            end
            ST_WAIT_FRAME: begin
                mux_hs = bus.vid_hsync;
                mux_vs = bus.vid_vsync;
                if (!enable)      state_nxt = ST_IDLE;
                else if (vs_rise) state_nxt = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                mux_de   = bus.vid_de;
                mux_hs   = bus.vid_hsync;
                mux_vs   = bus.vid_vsync;
                mux_data = pass_data;
                if (!enable) state_nxt = ST_STOPPING;
            end
            ST_STOPPING: begin
                mux_de   = bus.vid_de;
                mux_hs   = bus.vid_hsync;
                mux_vs   = bus.vid_vsync;
                mux_data = pass_data;
                // A pending re-enable keeps the stream running across the frame boundary.
                if (enable)       state_nxt = ST_ACTIVE;
                else if (vs_rise) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign stage_in = {mux_de, mux_hs ^ ~HSYNC_POL, mux_vs ^ ~VSYNC_POL, mux_data};
    assign chain    = {pipe_q, stage_in};

    // Output pipeline: every stage shifts every cycle, no stalls.
    always_ff @(posedge clk_pixel) begin
        if (rst) pipe_q <= {PIPE_STAGES{STAGE_RST}};
        else     pipe_q <= chain[PIPE_STAGES-1:0];
    end

    assign {bus.hdmi_de, bus.hdmi_hsync, bus.hdmi_vsync, bus.hdmi_data} = pipe_q[PIPE_STAGES-1];

    // Behavioural equivalent of the forwarding ODDR; its reset is tied off so it runs through rst.
    assign bus.hdmi_clk = clk_pixel ^ CLK_INVERT;

    assign line_bad = de_fall && line_ok && (state != ST_IDLE) && (line_cnt != CNT_EXP);

    // State register, edge detectors and line-length checker.
    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            state     <= ST_IDLE;
            active    <= 1'b0;
            vsync_d   <= 1'b1;
            de_d      <= 1'b0;
            line_ok   <= 1'b0;
            line_cnt  <= '0;
            line_err  <= 1'b0;
            err_count <= 8'd0;
        end else begin
            state   <= state_nxt;
            active  <= (state_nxt == ST_ACTIVE) || (state_nxt == ST_STOPPING);
            vsync_d <= bus.vid_vsync;
            de_d    <= bus.vid_de;

            if (de_rise) begin
                line_cnt <= CW'(1);
                line_ok  <= running;
            end else if (bus.vid_de && (line_cnt != CNT_MAX)) begin
                line_cnt <= line_cnt + CW'(1);
            end
            if (state == ST_IDLE) line_ok <= 1'b0;

            if (line_bad) begin
                line_err <= 1'b1;
                if (line_err_clr)             err_count <= 8'd1;
                else if (err_count != 8'hFF)  err_count <= err_count + 8'd1;
            end else if (line_err_clr) begin
                line_err  <= 1'b0;
                err_count <= 8'd0;
            end
        end
    end
endmodule

// File: tb/tb_hdmi_tx_formatter.sv
// Directed bench for hdmi_tx_formatter with PIPE_STAGES=3, ACTIVE_W=8, active-low HSYNC.
module tb_hdmi_tx_formatter;
    localparam int unsigned DW = 16;
    localparam int unsigned PS = 3;
    localparam int unsigned AW = 8;

    logic          clk_pixel = 1'b0;
    logic          rst;
    logic          enable;
    logic          force_mute;
    logic [DW-1:0] mute_color;
    logic          line_err_clr;
    logic          active;
    logic          line_err;
    logic [7:0]    err_count;

    int n_checks   = 0;
    int n_pass     = 0;
    int de_hi_total = 0;
    int s;

    always #5 clk_pixel = ~clk_pixel;

    hdmi_tx_formatter_if #(.DATA_W(DW)) bus ();

    hdmi_tx_formatter #(
        .DATA_W(DW), .PIPE_STAGES(PS), .ACTIVE_W(AW),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b1), .CLK_INVERT(1'b0)
    ) dut (
        .clk_pixel    (clk_pixel),
        .rst          (rst),
        .enable       (enable),
        .force_mute   (force_mute),
        .mute_color   (mute_color),
        .line_err_clr (line_err_clr),
        .bus          (bus.slave),
        .active       (active),
        .line_err     (line_err),
        .err_count    (err_count)
    );

    // Output DE-high cycles, for gap/gating checks over whole lines.
    always @(negedge clk_pixel) if (bus.hdmi_de) de_hi_total++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_pixel);
            #1;
        end
    endtask

    task automatic drive_line(input int n, input logic [DW-1:0] base);
        bus.vid_de = 1'b1;
        for (int i = 0; i < n; i++) begin
            bus.vid_data = base + 16'(i);
            cyc(1);
        end
        bus.vid_de   = 1'b0;
        bus.vid_data = '0;
        cyc(3);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] exp_px;
        int j;

        // Reset and IDLE
        rst = 1'b1; enable = 1'b0; force_mute = 1'b0; mute_color = 16'h8010; line_err_clr = 1'b0;
        bus.vid_data = 16'hAAAA; bus.vid_de = 1'b1; bus.vid_hsync = 1'b1; bus.vid_vsync = 1'b0;
        cyc(3);
        check("rst_hs",     32'(bus.hdmi_hsync), 32'd1);
        check("rst_vs",     32'(bus.hdmi_vsync), 32'd0);
        check("rst_de",     32'(bus.hdmi_de),    32'd0);
        check("rst_data",   32'(bus.hdmi_data),  32'd0);
        check("rst_active", 32'(active),         32'd0);
        check("rst_err",    32'(line_err),       32'd0);
        check("rst_cnt",    32'(err_count),      32'd0);
        check("clk_hi",     32'(bus.hdmi_clk),   32'd1);
        @(negedge clk_pixel); #1;
        check("clk_lo",     32'(bus.hdmi_clk),   32'd0);
        @(posedge clk_pixel); #1;
        rst = 1'b0;
        cyc(4);
        check("idle_hs",   32'(bus.hdmi_hsync), 32'd1);
        check("idle_de",   32'(bus.hdmi_de),    32'd0);
        check("idle_data", 32'(bus.hdmi_data),  32'd0);

        // Enable mid-frame: WAIT_FRAME passes syncs, gates DE
        bus.vid_hsync = 1'b0; bus.vid_de = 1'b0; bus.vid_data = '0;
        enable = 1'b1;
        cyc(1);
        check("wait_active", 32'(active), 32'd0);
        bus.vid_hsync = 1'b1; cyc(1); bus.vid_hsync = 1'b0; cyc(2);
        check("wait_hs_pass", 32'(bus.hdmi_hsync), 32'd0);
        s = de_hi_total;
        drive_line(8, 16'h0100);
        check("wait_gated", 32'(de_hi_total - s), 32'd0);
        bus.vid_vsync = 1'b1; bus.vid_de = 1'b1; bus.vid_data = 16'h0BAD;
        cyc(1);
        check("vs_active", 32'(active), 32'd1);
        bus.vid_vsync = 1'b0; bus.vid_de = 1'b0; bus.vid_data = '0;
        cyc(2);
        check("edge_vs",    32'(bus.hdmi_vsync), 32'd1);
        check("edge_gated", 32'(bus.hdmi_de),    32'd0);
        bus.vid_de = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.vid_data = 16'h1230 + 16'(i);
            cyc(1);
            if (i == 1) check("lat_de_early", 32'(bus.hdmi_de), 32'd0);
            if (i == 2) begin
                check("lat_de",  32'(bus.hdmi_de),   32'd1);
                check("lat_px0", 32'(bus.hdmi_data), 32'h1230);
            end
        end
        bus.vid_de = 1'b0; bus.vid_data = '0;
        cyc(3);
        check("line8_ok", 32'(line_err), 32'd0);

        // Line length checking
        drive_line(7, 16'h0200);
        check("line7_err", 32'(line_err),  32'd1);
        check("line7_cnt", 32'(err_count), 32'd1);
        drive_line(8, 16'h0300);
        check("line8_cnt", 32'(err_count), 32'd1);
        bus.vid_de = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bus.vid_data = 16'h0400 + 16'(i);
            cyc(1);
        end
        bus.vid_de = 1'b0; bus.vid_data = '0; line_err_clr = 1'b1;
        cyc(1);
        line_err_clr = 1'b0;
        check("clrset_err", 32'(line_err),  32'd1);
        check("clrset_cnt", 32'(err_count), 32'd1);
        line_err_clr = 1'b1; cyc(1); line_err_clr = 1'b0;
        check("clr_err", 32'(line_err),  32'd0);
        check("clr_cnt", 32'(err_count), 32'd0);
        drive_line(7, 16'h0500);
        drive_line(7, 16'h0600);
        check("cnt_two", 32'(err_count), 32'd2);
        for (int k = 0; k < 256; k++) drive_line(1, 16'h0700);
        check("cnt_sat", 32'(err_count), 32'd255);
        line_err_clr = 1'b1; cyc(1); line_err_clr = 1'b0;
        check("clr2_cnt", 32'(err_count), 32'd0);

        // Mute for four pixels of a line
        for (int i = 0; i < 10; i++) begin
            bus.vid_de   = (i < 8);
            bus.vid_data = (i < 8) ? 16'h2000 + 16'(i) : 16'h0000;
            force_mute   = (i >= 2 && i <= 5);
            cyc(1);
            if (i >= 2) begin
                j = i - 2;
                exp_px = (j >= 2 && j <= 5) ? 16'h8010 : 16'h2000 + 16'(j);
                check($sformatf("mute_de%0d", j), 32'(bus.hdmi_de),   32'd1);
                check($sformatf("mute_px%0d", j), 32'(bus.hdmi_data), 32'(exp_px));
            end
        end
        cyc(2);
        check("mute_line_ok", 32'(line_err), 32'd0);

        // Disable mid-frame: video runs to the next VSYNC edge
        enable = 1'b0;
        cyc(1);
        check("stop_active", 32'(active), 32'd1);
        s = de_hi_total;
        drive_line(8, 16'h3000);
        check("stop_pass", 32'(de_hi_total - s), 32'd8);
        bus.vid_vsync = 1'b1; bus.vid_hsync = 1'b1; bus.vid_de = 1'b1; bus.vid_data = 16'h3333;
        cyc(1);
        check("stop_idle", 32'(active), 32'd0);
        bus.vid_data = 16'h4444;
        cyc(2);
        check("edge_de",   32'(bus.hdmi_de),    32'd1);
        check("edge_data", 32'(bus.hdmi_data),  32'h3333);
        check("edge_vs2",  32'(bus.hdmi_vsync), 32'd1);
        check("edge_hs",   32'(bus.hdmi_hsync), 32'd0);
        cyc(1);
        check("off_de",   32'(bus.hdmi_de),    32'd0);
        check("off_data", 32'(bus.hdmi_data),  32'd0);
        check("off_vs",   32'(bus.hdmi_vsync), 32'd0);
        check("off_hs",   32'(bus.hdmi_hsync), 32'd1);
        bus.vid_de = 1'b0; bus.vid_vsync = 1'b0; bus.vid_hsync = 1'b0; bus.vid_data = '0;
        cyc(3);
        check("abandon_err", 32'(line_err),  32'd0);
        check("abandon_cnt", 32'(err_count), 32'd0);

        // Re-enable while STOPPING keeps the stream across VSYNC
        enable = 1'b1; cyc(2);
        bus.vid_vsync = 1'b1; cyc(1); bus.vid_vsync = 1'b0; cyc(1);
        check("re_active", 32'(active), 32'd1);
        enable = 1'b0; cyc(2);
        enable = 1'b1; cyc(1);
        bus.vid_vsync = 1'b1; cyc(1); bus.vid_vsync = 1'b0; cyc(1);
        s = de_hi_total;
        drive_line(8, 16'h6000);
        check("nogap_de",     32'(de_hi_total - s), 32'd8);
        check("nogap_active", 32'(active),          32'd1);

        // Reset mid-line in ACTIVE
        drive_line(7, 16'h4000);
        check("pre_rst_cnt", 32'(err_count), 32'd1);
        bus.vid_de = 1'b1; bus.vid_hsync = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.vid_data = 16'h5000 + 16'(i);
            cyc(1);
        end
        rst = 1'b1; cyc(1); rst = 1'b0;
        check("mrst_active", 32'(active), 32'd0);
        cyc(2);
        check("mrst_de",   32'(bus.hdmi_de),    32'd0);
        check("mrst_data", 32'(bus.hdmi_data),  32'd0);
        check("mrst_hs",   32'(bus.hdmi_hsync), 32'd1);
        check("mrst_vs",   32'(bus.hdmi_vsync), 32'd0);
        bus.vid_de = 1'b0; bus.vid_hsync = 1'b0; bus.vid_data = '0;
        cyc(3);
        check("trunc_err", 32'(line_err),  32'd0);
        check("trunc_cnt", 32'(err_count), 32'd0);

        // enable=0 beats a simultaneous VSYNC edge in WAIT_FRAME
        enable = 1'b0; bus.vid_vsync = 1'b1;
        cyc(1);
        check("wait_prio", 32'(active), 32'd0);
        bus.vid_vsync = 1'b0;
        cyc(2);
        check("wait_prio2", 32'(active), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
